// File: rtl/dac_pair_spi_driver.sv
// Serialises 14-bit A/B sample pairs into two SPI frames and then fires one
// shared ldac_n strobe so both DAC channels update together.
module dac_pair_spi_driver #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned LDAC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sample_valid,
  input  logic [13:0] din_a,
  input  logic [13:0] din_b,
  output logic        sample_ready,
  output logic        sclk,
  output logic        sync_n,
  output logic        sdata,
  output logic        ldac_n,
  output logic        busy,
  output logic        pair_done
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned DATA_W  = 14;
  localparam int unsigned SHIFT_W = 16;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SHIFT_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    FRAME_A,
    GAP,
    FRAME_B,
    LDAC
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   hold_a;
  logic [DATA_W-1:0]   hold_b;
  logic                hold_full;
  logic [DATA_W-1:0]   latch_b;
  logic [SHIFT_W-1:0]  shift;
  logic [CNT_W-1:0]    div_cnt;
  logic [CNT_W-1:0]    cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic                capture;
  logic                load;

  assign sample_ready = en & ~hold_full;
  assign capture      = sample_valid & sample_ready;
  assign load         = (state == IDLE) & hold_full;

  // Single-entry holding register; a capture takes priority over the load clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_a    <= '0;
      hold_b    <= '0;
    end else if (capture) begin
      hold_full <= 1'b1;
      hold_a    <= din_a;
      hold_b    <= din_b;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Frame sequencer: every output is updated on the edge that enters its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      latch_b   <= '0;
      shift     <= '0;
      div_cnt   <= '0;
      cnt       <= '0;
      bit_cnt   <= '0;
      sclk      <= 1'b0;
      sdata     <= 1'b0;
      sync_n    <= 1'b1;
      ldac_n    <= 1'b1;
      busy      <= 1'b0;
      pair_done <= 1'b0;
    end else begin
      pair_done <= 1'b0;
      case (state)
        IDLE: begin
          if (hold_full) begin
            shift   <= {2'b00, hold_a};
            latch_b <= hold_b;
            sdata   <= 1'b0;
            sclk    <= 1'b0;
            sync_n  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= FRAME_A;
          end
        end
        FRAME_A, FRAME_B: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bit_cnt != BIT_LAST) begin
              // Next bit: rotate so the upcoming MSB lands in shift[15].
              sclk    <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= {shift[SHIFT_W-2:0], shift[SHIFT_W-1]};
              sdata   <= shift[SHIFT_W-2];
            end else begin
              sclk   <= 1'b0;
              sdata  <= 1'b0;
              sync_n <= 1'b1;
              cnt    <= '0;
              if (state == FRAME_A) begin
                state <= GAP;
              end else begin
                ldac_n    <= 1'b0;
                pair_done <= (LDAC_LAST == '0);
                state     <= LDAC;
              end
            end
          end
        end
        GAP: begin
          if (cnt != GAP_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            shift   <= {2'b01, latch_b};
            sdata   <= 1'b0;
            sync_n  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= FRAME_B;
          end
        end
        LDAC: begin
          if (cnt != LDAC_LAST) begin
            cnt       <= cnt + 1'b1;
            pair_done <= ((cnt + 1'b1) == LDAC_LAST);
          end else begin
            ldac_n <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_pair_spi_driver.sv
// Bench for dac_pair_spi_driver: decodes the SPI/LDAC waveforms and compares
// them against a timeline model built from frame, gap and strobe lengths.
module tb_dac_pair_spi_driver;

  localparam int D         = 2;
  localparam int G         = 2;
  localparam int L         = 2;
  localparam int FRAME_LEN = 32 * D;

  logic        clk = 1'b0;
  logic        rst_n, en, sample_valid;
  logic [13:0] din_a, din_b;
  logic        sample_ready, sclk, sync_n, sdata, ldac_n, busy, pair_done;
  logic        f_en, f_valid;
  logic [13:0] f_din_a, f_din_b;
  logic        f_ready, f_sclk, f_sync_n, f_sdata, f_ldac_n, f_busy, f_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  dac_pair_spi_driver u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sample_valid(sample_valid),
    .din_a(din_a), .din_b(din_b), .sample_ready(sample_ready), .sclk(sclk),
    .sync_n(sync_n), .sdata(sdata), .ldac_n(ldac_n), .busy(busy),
    .pair_done(pair_done)
  );

  dac_pair_spi_driver #(.CLK_DIV(1), .GAP_CYCLES(1), .LDAC_CYCLES(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .en(f_en), .sample_valid(f_valid),
    .din_a(f_din_a), .din_b(f_din_b), .sample_ready(f_ready), .sclk(f_sclk),
    .sync_n(f_sync_n), .sdata(f_sdata), .ldac_n(f_ldac_n), .busy(f_busy),
    .pair_done(f_done)
  );

  always #5 clk = ~clk;

  // Waveform decoder for the default-parameter instance
  typedef struct {
    logic [15:0] word;
    int nbits;
    int bad_run;
    int start;
    int stop;
  } frame_t;

  frame_t frames[$];
  frame_t cur;
  int ldac_start[$], ldac_stop[$], done_at[$];
  int proto_err = 0;
  int cyc = 0;
  int run = 0;
  int lst = 0;
  logic p_sclk = 1'b0, p_sdata = 1'b0, p_sync = 1'b1, p_ldac = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      p_sclk = 1'b0; p_sdata = 1'b0; p_sync = 1'b1; p_ldac = 1'b1;
    end else begin
      if (p_sync && !sync_n) begin
        cur.word = '0; cur.nbits = 0; cur.bad_run = sclk ? 1 : 0;
        cur.start = cyc; run = 1;
      end else if (!sync_n) begin
        if (sclk == p_sclk) run++;
        else begin
          if (run != D) cur.bad_run++;
          run = 1;
        end
      end
      if (!sync_n && sclk && !p_sclk) begin
        cur.word = {cur.word[14:0], sdata};
        cur.nbits++;
      end
      if (!p_sync && sync_n) begin
        if (run != D) cur.bad_run++;
        cur.stop = cyc;
        frames.push_back(cur);
      end
      if (sync_n && sclk) proto_err++;
      if (sclk && (sdata !== p_sdata)) proto_err++;
      if (!sync_n && !ldac_n) proto_err++;
      if (!busy && (sclk || sdata || !sync_n || !ldac_n || pair_done)) proto_err++;
      if (p_ldac && !ldac_n) lst = cyc;
      if (!p_ldac && ldac_n) begin
        ldac_start.push_back(lst);
        ldac_stop.push_back(cyc);
      end
      if (pair_done) done_at.push_back(cyc);
      p_sclk = sclk; p_sdata = sdata; p_sync = sync_n; p_ldac = ldac_n;
    end
  end

  task automatic clear_mon();
    frames.delete(); ldac_start.delete(); ldac_stop.delete(); done_at.delete();
    proto_err = 0;
  endtask

  // Present a pair and hold it until accepted; capn = decoder cycle of the capture.
  task automatic send_pair(input logic [13:0] a, input logic [13:0] b,
                           input int budget, output int capn);
    int n = 0;
    @(posedge clk); #1;
    sample_valid = 1'b1; din_a = a; din_b = b;
    while (!sample_ready && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (!sample_ready) begin
      sample_valid = 1'b0; capn = -1;
      return;
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    capn = cyc + 1;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int k = 0;
    while (done_at.size() < n && k < budget) begin
      @(negedge clk); k++;
    end
    ok = (done_at.size() >= n);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; sample_valid = 1'b0; din_a = '0; din_b = '0;
    f_en = 1'b0; f_valid = 1'b0; f_din_a = '0; f_din_b = '0;
    repeat (3) @(posedge clk); #1;
    total_cnt++;
    if ({sync_n, ldac_n, sclk, sdata} !== 4'b1100) $display("FAIL reset_lines: got %b want 1100", {sync_n, ldac_n, sclk, sdata});
    else pass_cnt++;
    total_cnt++;
    if ({busy, pair_done} !== 2'b00) $display("FAIL reset_status: got %b want 00", {busy, pair_done});
    else pass_cnt++;
    total_cnt++;
    if (sample_ready !== 1'b0) $display("FAIL reset_ready_en0: got %b want 0", sample_ready);
    else pass_cnt++;
    rst_n = 1'b1; en = 1'b1; #1;
    total_cnt++;
    if (sample_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", sample_ready);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    int capn;
    bit ok;
    frame_t fa, fb;
    clear_mon();
    send_pair(14'h2000, 14'h3FFF, 10, capn);
    total_cnt++;
    if (sample_ready !== 1'b0 || capn < 0) $display("FAIL dir_ready_after_capture: got %b want 0 (cap %0d)", sample_ready, capn);
    else pass_cnt++;
    repeat (10) @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL dir_busy: got %b want 1", busy);
    else pass_cnt++;
    wait_done(1, 400, ok);
    total_cnt++;
    if (!ok || frames.size() != 2 || ldac_stop.size() != 1 || done_at.size() != 1) begin
      $display("FAIL dir_counts: got frames %0d ldac %0d done %0d want 2 1 1", frames.size(), ldac_stop.size(), done_at.size());
      return;
    end
    pass_cnt++;
    fa = frames[0]; fb = frames[1];
    total_cnt++;
    if (fa.word !== 16'h2000) $display("FAIL dir_word_a: got %h want 2000", fa.word);
    else pass_cnt++;
    total_cnt++;
    if (fb.word !== 16'h7FFF) $display("FAIL dir_word_b: got %h want 7fff", fb.word);
    else pass_cnt++;
    total_cnt++;
    if (fa.start !== capn + 1) $display("FAIL dir_start: got %0d want %0d", fa.start, capn + 1);
    else pass_cnt++;
    total_cnt++;
    if (fa.stop - fa.start !== 64 || fb.stop - fb.start !== 64) $display("FAIL dir_sync_len: got %0d/%0d want 64/64", fa.stop - fa.start, fb.stop - fb.start);
    else pass_cnt++;
    total_cnt++;
    if (fb.start - fa.stop !== 2) $display("FAIL dir_gap: got %0d want 2", fb.start - fa.stop);
    else pass_cnt++;
    total_cnt++;
    if (fa.nbits + fb.nbits !== 32 || fa.bad_run + fb.bad_run !== 0) $display("FAIL dir_bits: got bits %0d bad %0d want 32 0", fa.nbits + fb.nbits, fa.bad_run + fb.bad_run);
    else pass_cnt++;
    total_cnt++;
    if (ldac_start[0] !== fb.stop || ldac_stop[0] - ldac_start[0] !== 2) $display("FAIL dir_ldac: got start %0d len %0d want %0d 2", ldac_start[0], ldac_stop[0] - ldac_start[0], fb.stop);
    else pass_cnt++;
    total_cnt++;
    if (done_at[0] !== fb.stop + 1) $display("FAIL dir_done: got %0d want %0d", done_at[0], fb.stop + 1);
    else pass_cnt++;
    total_cnt++;
    if (proto_err !== 0) $display("FAIL dir_protocol: got %0d violations want 0", proto_err);
    else pass_cnt++;
  endtask

  task automatic test_clkdiv1();
    logic sy[80], sc[80], sd[80], ld[80], dn[80];
    logic [15:0] exp_a, exp_b;
    int s0 = -1;
    int e_clk = 0;
    int e_dat = 0;
    int e_tail = 0;
    exp_a = {2'b00, 14'h1555};
    exp_b = {2'b01, 14'($urandom)};
    f_en = 1'b1;
    @(posedge clk); #1;
    f_valid = 1'b1; f_din_a = exp_a[13:0]; f_din_b = exp_b[13:0];
    @(posedge clk); #1;
    f_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      sy[i] = f_sync_n; sc[i] = f_sclk; sd[i] = f_sdata; ld[i] = f_ldac_n; dn[i] = f_done;
    end
    f_en = 1'b0;
    for (int i = 0; i < 10; i++) if (s0 < 0 && sy[i] == 1'b0) s0 = i;
    total_cnt++;
    if (s0 !== 1) begin
      $display("FAIL fast_start: got %0d want 1", s0);
      return;
    end
    pass_cnt++;
    for (int k = 0; k < 32; k++) begin
      if (sy[s0 + k] !== 1'b0 || sc[s0 + k] !== 1'(k % 2)) e_clk++;
      if (sy[s0 + 33 + k] !== 1'b0 || sc[s0 + 33 + k] !== 1'(k % 2)) e_clk++;
    end
    for (int j = 0; j < 16; j++) begin
      if (sd[s0 + 2*j] !== exp_a[15 - j] || sd[s0 + 2*j + 1] !== exp_a[15 - j]) e_dat++;
      if (sd[s0 + 33 + 2*j] !== exp_b[15 - j] || sd[s0 + 34 + 2*j] !== exp_b[15 - j]) e_dat++;
    end
    if (sy[s0 + 32] !== 1'b1 || sc[s0 + 32] !== 1'b0) e_tail++;
    if (sy[s0 + 65] !== 1'b1 || ld[s0 + 65] !== 1'b0 || dn[s0 + 65] !== 1'b1) e_tail++;
    if (ld[s0 + 66] !== 1'b1 || dn[s0 + 66] !== 1'b0 || dn[s0 + 64] !== 1'b0 || ld[s0 + 64] !== 1'b1) e_tail++;
    total_cnt++;
    if (e_clk !== 0) $display("FAIL fast_sclk_toggle: got %0d bad cycles want 0", e_clk);
    else pass_cnt++;
    total_cnt++;
    if (e_dat !== 0) $display("FAIL fast_sdata: got %0d bad bits want 0", e_dat);
    else pass_cnt++;
    total_cnt++;
    if (e_tail !== 0) $display("FAIL fast_gap_ldac: got %0d bad points want 0", e_tail);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    int n = 0;
    int rdy_hi = 0;
    bit ok;
    logic [13:0] a1, b1, a2, b2;
    a1 = 14'($urandom); b1 = 14'($urandom); a2 = 14'($urandom); b2 = 14'($urandom);
    clear_mon();
    send_pair(a1, b1, 10, c1);
    while (sync_n && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    total_cnt++;
    if (sample_ready !== 1'b1) $display("FAIL b2b_ready_second: got %b want 1", sample_ready);
    else pass_cnt++;
    send_pair(a2, b2, 10, c2);
    total_cnt++;
    if (sample_ready !== 1'b0 || c2 < 0) $display("FAIL b2b_ready_after_second: got %b want 0", sample_ready);
    else pass_cnt++;
    sample_valid = 1'b1; din_a = ~a2; din_b = ~b2;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (sample_ready) rdy_hi++;
    end
    sample_valid = 1'b0;
    total_cnt++;
    if (rdy_hi !== 0) $display("FAIL b2b_third_ready: got %0d ready cycles want 0", rdy_hi);
    else pass_cnt++;
    wait_done(2, 600, ok);
    repeat (150) @(negedge clk);
    total_cnt++;
    if (!ok || frames.size() != 4 || done_at.size() != 2) begin
      $display("FAIL b2b_counts: got frames %0d done %0d want 4 2", frames.size(), done_at.size());
      return;
    end
    pass_cnt++;
    total_cnt++;
    if ({frames[0].word, frames[1].word, frames[2].word, frames[3].word} !== {2'b00, a1, 2'b01, b1, 2'b00, a2, 2'b01, b2})
      $display("FAIL b2b_words: got %h %h %h %h want %h %h %h %h", frames[0].word, frames[1].word, frames[2].word, frames[3].word,
               {2'b00, a1}, {2'b01, b1}, {2'b00, a2}, {2'b01, b2});
    else pass_cnt++;
    total_cnt++;
    if (frames[2].start !== done_at[0] + 2) $display("FAIL b2b_idle_gap: got %0d want %0d", frames[2].start, done_at[0] + 2);
    else pass_cnt++;
    total_cnt++;
    if (proto_err !== 0) $display("FAIL b2b_protocol: got %0d violations want 0", proto_err);
    else pass_cnt++;
  endtask

  task automatic test_random();
    localparam int N = 8;
    logic [13:0] a_q[$], b_q[$];
    int cap_q[$];
    int capn, st, dn, delay;
    int prev_done = -1000;
    bit ok;
    frame_t fa, fb;
    clear_mon();
    for (int i = 0; i < N; i++) begin
      delay = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 160);
      repeat (delay) @(posedge clk);
      a_q.push_back(14'($urandom)); b_q.push_back(14'($urandom));
      send_pair(a_q[i], b_q[i], 2000, capn);
      cap_q.push_back(capn);
    end
    wait_done(N, 3000, ok);
    total_cnt++;
    if (!ok || frames.size() != 2*N || done_at.size() != N || ldac_stop.size() != N) begin
      $display("FAIL rnd_counts: got frames %0d done %0d ldac %0d want %0d %0d %0d",
               frames.size(), done_at.size(), ldac_stop.size(), 2*N, N, N);
      return;
    end
    pass_cnt++;
    for (int i = 0; i < N; i++) begin
      st = (cap_q[i] + 1 > prev_done + 2) ? cap_q[i] + 1 : prev_done + 2;
      dn = st + 2*FRAME_LEN + G + L - 1;
      prev_done = dn;
      fa = frames[2*i]; fb = frames[2*i + 1];
      total_cnt++;
      if ({fa.word, fb.word} !== {2'b00, a_q[i], 2'b01, b_q[i]})
        $display("FAIL rnd_words[%0d]: got %h %h want %h %h", i, fa.word, fb.word, {2'b00, a_q[i]}, {2'b01, b_q[i]});
      else pass_cnt++;
      total_cnt++;
      if (fa.start !== st) $display("FAIL rnd_start[%0d]: got %0d want %0d", i, fa.start, st);
      else pass_cnt++;
      total_cnt++;
      if (fa.stop - fa.start !== FRAME_LEN || fb.start - fa.stop !== G || fb.stop - fb.start !== FRAME_LEN
          || fa.nbits !== 16 || fb.nbits !== 16 || fa.bad_run + fb.bad_run !== 0)
        $display("FAIL rnd_shape[%0d]: got lenA %0d gap %0d lenB %0d bits %0d/%0d bad %0d want %0d %0d %0d 16/16 0",
                 i, fa.stop - fa.start, fb.start - fa.stop, fb.stop - fb.start, fa.nbits, fb.nbits,
                 fa.bad_run + fb.bad_run, FRAME_LEN, G, FRAME_LEN);
      else pass_cnt++;
      total_cnt++;
      if (ldac_start[i] !== fb.stop || ldac_stop[i] - ldac_start[i] !== L || done_at[i] !== dn)
        $display("FAIL rnd_ldac[%0d]: got start %0d len %0d done %0d want %0d %0d %0d",
                 i, ldac_start[i], ldac_stop[i] - ldac_start[i], done_at[i], fb.stop, L, dn);
      else pass_cnt++;
    end
    total_cnt++;
    if (proto_err !== 0) $display("FAIL rnd_protocol: got %0d violations want 0", proto_err);
    else pass_cnt++;
  endtask

  task automatic test_en_low();
    int rdy_hi = 0;
    int c1, c2;
    int n = 0;
    bit ok;
    logic [13:0] a1, b1, a2, b2;
    a1 = 14'($urandom); b1 = 14'($urandom); a2 = 14'($urandom); b2 = 14'($urandom);
    clear_mon();
    @(posedge clk); #1;
    en = 1'b0; sample_valid = 1'b1; din_a = a1; din_b = b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (sample_ready) rdy_hi++;
    end
    sample_valid = 1'b0;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (rdy_hi !== 0 || frames.size() != 0 || busy !== 1'b0)
      $display("FAIL en0_no_accept: got ready %0d frames %0d busy %b want 0 0 0", rdy_hi, frames.size(), busy);
    else pass_cnt++;
    en = 1'b1;
    send_pair(a1, b1, 10, c1);
    send_pair(a2, b2, 200, c2);
    while (frames.size() < 1 && n < 300) begin @(negedge clk); n++; end
    en = 1'b0;
    #1;
    total_cnt++;
    if (sample_ready !== 1'b0 || sync_n !== 1'b1 || c2 < 0) $display("FAIL en0_drop_in_gap: got ready %b sync_n %b want 0 1", sample_ready, sync_n);
    else pass_cnt++;
    wait_done(2, 600, ok);
    total_cnt++;
    if (!ok || frames.size() != 4 || ldac_stop.size() != 2) begin
      $display("FAIL en0_complete: got frames %0d ldac %0d want 4 2", frames.size(), ldac_stop.size());
    end else if ({frames[1].word, frames[3].word} !== {2'b01, b1, 2'b01, b2}) begin
      $display("FAIL en0_complete: got B words %h %h want %h %h", frames[1].word, frames[3].word, {2'b01, b1}, {2'b01, b2});
    end else pass_cnt++;
    en = 1'b1;
  endtask

  task automatic test_reset_midframe();
    int capn;
    int n = 0;
    int ld_low = 0;
    int dn_hi = 0;
    int sy_low = 0;
    clear_mon();
    send_pair(14'($urandom), 14'($urandom), 10, capn);
    while (!(frames.size() == 1 && !sync_n && cur.nbits == 7 && !sclk) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    total_cnt++;
    if (n >= 400) begin
      $display("FAIL rst_mid_reach: got no frame B bit 7 want bit 7 reached");
      return;
    end
    pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({sync_n, ldac_n, sclk, sdata, busy, pair_done} !== 6'b110000)
      $display("FAIL rst_mid_async: got %b want 110000", {sync_n, ldac_n, sclk, sdata, busy, pair_done});
    else pass_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!ldac_n) ld_low++;
      if (pair_done) dn_hi++;
      if (!sync_n) sy_low++;
    end
    total_cnt++;
    if (ld_low !== 0 || dn_hi !== 0 || sy_low !== 0 || busy !== 1'b0)
      $display("FAIL rst_mid_aftermath: got ldac %0d done %0d sync %0d busy %b want 0 0 0 0", ld_low, dn_hi, sy_low, busy);
    else pass_cnt++;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_clkdiv1();
    test_back_to_back();
    test_random();
    test_en_low();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
